// File: rtl/tile_game_ctrl.sv
// Game sequencer for the seven-line tile shift register: paces shifts, judges lane-key
// presses against the bottom line, and tracks score, lives and difficulty.
module tile_game_ctrl #(
  parameter logic [23:0] TICK_INIT     = 24'd12_500_000,
  parameter logic [23:0] TICK_MIN      = 24'd3_125_000,
  parameter logic [23:0] TICK_STEP     = 24'd1_000_000,
  parameter logic [7:0]  SPEEDUP_EVERY = 8'd10,
  parameter logic [1:0]  LIVES         = 2'd3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       startn,
  input  logic [3:0] key,
  input  logic [2:0] line_6,
  output logic [5:0] current_st,
  output logic       shift,
  output logic       correct_in,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  typedef enum logic [5:0] {
    StIdle = 6'd0,
    StPlay = 6'd1,
    StOver = 6'd2
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] period_q, period_d;
  logic [3:0]  key_prev_q, key_prev_d;
  logic        block_q, block_d;
  logic        shift_q, shift_d;
  logic        correct_q, correct_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;

  logic [3:0]  lane_mask;
  logic [3:0]  new_press;
  logic        press, hit, wrong, miss, speedup;
  logic [7:0]  score_inc;
  logic [24:0] period_sub;
  logic [23:0] period_dn;

  // Judge the current press against the bottom line and precompute the next period.
  always_comb begin
    lane_mask = 4'b0000;
    case (line_6)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0010;
      3'd3:    lane_mask = 4'b0100;
      3'd4:    lane_mask = 4'b1000;
      default: lane_mask = 4'b0000;
    endcase
    new_press  = key & ~key_prev_q;
    // A just-cleared line_6 is stale for one cycle, so presses are ignored then.
    press      = (new_press != 4'b0000) && !block_q;
    hit        = press && (new_press == lane_mask);
    wrong      = press && !hit;
    miss       = shift_q && (line_6 != 3'd0);
    score_inc  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    speedup    = (score_inc % SPEEDUP_EVERY) == 8'd0;
    period_sub = {1'b0, period_q} - {1'b0, TICK_STEP};
    period_dn  = (period_sub[24] || (period_sub[23:0] < TICK_MIN)) ? TICK_MIN : period_sub[23:0];
  end

  // Next-state logic: game FSM, shift pacing with hit-priority deferral, score and lives.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    key_prev_d = key;
    block_d    = 1'b0;
    shift_d    = 1'b0;
    correct_d  = 1'b0;
    score_d    = score_q;
    lives_d    = lives_q;
    case (state_q)
      StIdle: begin
        if (!startn) begin
          state_d  = StPlay;
          score_d  = 8'd0;
          lives_d  = LIVES;
          period_d = TICK_INIT;
          cnt_d    = TICK_INIT - 24'd1;
        end
      end
      StPlay: begin
        // shift_q is high exactly while cnt_q is 0; a 0 without shift_q is a deferred shift.
        if (cnt_q != 24'd0) begin
          cnt_d = cnt_q - 24'd1;
        end else if (shift_q) begin
          cnt_d = period_q - 24'd1;
        end else begin
          cnt_d = 24'd0;
        end
        shift_d   = (cnt_d == 24'd0) && !hit;
        correct_d = hit;
        block_d   = hit;
        if (hit) begin
          score_d = score_inc;
          if (speedup) begin
            period_d = period_dn;
          end
        end
        if (wrong || miss) begin
          if (lives_q <= 2'd1) begin
            lives_d   = 2'd0;
            state_d   = StOver;
            shift_d   = 1'b0;
            correct_d = 1'b0;
          end else begin
            lives_d = lives_q - 2'd1;
          end
        end
      end
      StOver: begin
        if (!startn) begin
          state_d = StIdle;
          score_d = 8'd0;
          lives_d = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= 24'd0;
      period_q   <= TICK_INIT;
      key_prev_q <= 4'b0000;
      block_q    <= 1'b0;
      shift_q    <= 1'b0;
      correct_q  <= 1'b0;
      score_q    <= 8'd0;
      lives_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      key_prev_q <= key_prev_d;
      block_q    <= block_d;
      shift_q    <= shift_d;
      correct_q  <= correct_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
    end
  end

  assign current_st = state_q;
  assign shift      = shift_q;
  assign correct_in = correct_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_over  = (state_q == StOver);

endmodule

// File: doc/tile_game_ctrl.md
# tile_game_ctrl

Game sequencer for the seven-line tile shift register. It produces the `shift` pacing pulses and judges lane-key presses against the bottom line (`line_6`). On a hit it issues the `correct_in` clear pulse. It also keeps score, lives and difficulty, and presents the `current_st` code that the shift register uses for its start-of-game clear.

## Interface
- `TICK_INIT`, 24'd12_500_000: initial shift period in clk cycles (≥2).
- `TICK_MIN`, 24'd3_125_000: fastest allowed period (≥2, ≤TICK_INIT).
- `TICK_STEP`, 24'd1_000_000: period reduction per speed-up.
- `SPEEDUP_EVERY`, 8'd10: correct hits between speed-ups (≥1).
- `LIVES`, 2'd3: lives at game start (1..3).
- `clk` in 1: system clock, all logic on posedge.
- `resetn` in 1: asynchronous, active-low reset.
- `startn` in 1: start button, active-low, already synchronised.
- `key` in 4: lane buttons, active-high, already synchronised; `key[i]` corresponds to lane code i+1.
- `line_6` in 3: bottom line from the shift register; 0 = empty, 1..4 = tile lane.
- `current_st` out 6: state code.
- `shift` out 1: one-cycle advance pulse.
- `correct_in` out 1: one-cycle clear-bottom-line pulse.
- `score` out 8: correct hits, saturating.
- `lives` out 2: remaining lives.
- `game_over` out 1: high in OVER.

## Operation
- Reset (async, resetn=0): state IDLE; `current_st`=0, `shift`=0, `correct_in`=0, `score`=0, `lives`=0, `game_over`=0; period=TICK_INIT; tick counter=0; `key_prev`=0; `block`=0.
- States and codes: IDLE=6'd0, PLAY=6'd1, OVER=6'd2.
- IDLE:
  - Outputs 0.
  - On `startn`=0: go to PLAY, `score`=0, `lives`=LIVES, period=TICK_INIT, counter=TICK_INIT-1, `key_prev`=`key`.
  - The shift register clears its lines during this IDLE cycle.
- PLAY, tick logic:
  - The counter decrements each cycle.
  - At counter==0 the block requests a shift and reloads the counter with period-1.
- PLAY, press event: `new` = `key` & ~`key_prev`; `key_prev`<=`key` every cycle.
  - No press: `new`==0 or `block`=1.
  - Hit: exactly one bit of `new` set, `line_6`≠0, and that bit index equals `line_6`-1.
  - Wrong press: any other nonzero `new`, including multiple bits, or any press while `line_6`==0.
- Hit handling:
  - Register `correct_in`=1 for the next cycle.
  - `score`+1, saturating at 255.
  - Set `block`=1 for one cycle, because `line_6` is stale until the clear lands.
  - When `score` (post-increment) is a multiple of SPEEDUP_EVERY: period = max(period-TICK_STEP, TICK_MIN). Compute with a 25-bit subtract so there is no underflow.
- Collision: the shift register gives `correct_in` priority over `shift`.
  - If a shift request and a hit occur in the same cycle, only `correct_in` is issued.
  - The counter is held at 0, so the shift is issued in the following cycle.
  - `shift` and `correct_in` are never high together.
- Miss: in any cycle where `shift`=1 and `line_6`≠0, the uncleared tile drops off and counts as a miss.
- Life loss: a wrong press and/or a miss in the same cycle costs exactly 1 life.
  - When `lives` would reach 0, go to OVER.
- OVER:
  - `game_over`=1; `shift` and `correct_in` held 0.
  - `score` and `lives` (=0) hold.
  - On `startn`=0: go to IDLE, which then proceeds normally.
- `resetn` low in any state, mid-pulse included: all state cleared immediately; any pending shift is discarded.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- First PLAY cycle = P1. The first `shift` is high in cycle P(TICK_INIT); after that, `shift` repeats every `period` cycles.
- A key rising edge sampled at edge N gives `correct_in` high during cycle N+1. `line_6` reads 0 from cycle N+2.
- A deferred shift is delayed by exactly 1 cycle. Later shifts keep their reloaded period, measured from the deferred pulse.
- `score`, `lives` and `period` update on the same edge that registers the `correct_in` or life-loss event.
- A held key generates a press event only once.
- Any transition out of IDLE or OVER takes 1 cycle after `startn` is sampled low.

## Test plan
Parameters for all scenarios: TICK_INIT=8, TICK_MIN=2, TICK_STEP=2, SPEEDUP_EVERY=2, LIVES=3.
- Reset, then `startn` pulse, with no keys:
  - `current_st` goes 0→1.
  - `shift` is high in P8, P16 and P24.
  - `lives`=3 throughout while `line_6`=0.
- `line_6`=3, rising edge on `key[2]`:
  - `correct_in` is high for 1 cycle next cycle; `score`=1.
  - A second hit gives `score`=2 and the shift spacing becomes 6, then 4 and 2 on later speed-ups, never below 2.
- `line_6`=3, press `key[0]`; separately, press `key[1]|key[2]` together:
  - Each press costs 1 life.
  - No `correct_in` in either case.
- Collision: a hit press is sampled in the cycle before counter==0:
  - `correct_in` is high in cycle X and `shift` is high in X+1.
  - They are never high together.
- Three misses (`line_6`=1 held while `shift` fires):
  - `lives` goes 3→2→1→0, then `current_st`=2 and `game_over`=1, with no further `shift`.
  - `startn` returns the block to IDLE, then PLAY, with `lives`=3 and `score`=0.
- `resetn` low asynchronously mid-PLAY, between clock edges:
  - All outputs read 0 before the next edge.
  - After release the block stays in IDLE until `startn`.
